cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
Shares the single line-granularity port to physical memory (or L2) between the L1 instruction cache and the L1 data cache. It sits inside the cache top, below both L1 controllers and above the pmem/L2 interface. The arbiter latches one requester's transaction and drives it downstream until the response arrives. It routes the response back to that requester only, and resolves contention by round-robin or fixed data priority.

Parameters:
LINE_W, 256, cache line width in bits
ADDR_W, 32, address width (line-aligned; low 5 bits forwarded unchanged)
D_PRIORITY, 0, 0 = round-robin on simultaneous requests; 1 = dcache always wins

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_addr  in  ADDR_W  icache line address
i_read  in  1  icache line read request, held until i_resp
i_rdata  out  LINE_W  line data to icache
i_resp  out  1  one-cycle completion pulse to icache
d_addr  in  ADDR_W  dcache line address
d_read  in  1  dcache line read (fill) request
d_write  in  1  dcache line write (writeback) request
d_wdata  in  LINE_W  writeback line
d_rdata  out  LINE_W  line data to dcache
d_resp  out  1  one-cycle completion pulse to dcache
mem_addr  out  ADDR_W  downstream address
mem_read  out  1  downstream read
mem_write  out  1  downstream write
mem_wdata  out  LINE_W  downstream write line
mem_rdata  in  LINE_W  downstream read line
mem_resp  in  1  downstream completion, one cycle
grant_i_cnt  out  32  count of icache transactions completed
grant_d_cnt  out  32  count of dcache transactions completed
conflict_cnt  out  32  count of IDLE cycles with both requesters pending

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high. Both are decided.
- States: IDLE, BUSY_I, BUSY_D.
- Reset: state = IDLE; last_grant = I, so the first tie goes to D; latched addr/wdata/op = 0; all counters = 0.
- Reset values of outputs: mem_read = mem_write = 0, i_resp = d_resp = 0, mem_addr = mem_wdata = 0.
- IDLE: at the clock edge, take pending_i = i_read and pending_d = d_read | d_write.
  - Only one pending: grant it.
  - Both pending with D_PRIORITY = 1: grant D.
  - Both pending with D_PRIORITY = 0: grant the requester opposite to last_grant.
  - On grant: latch addr; latch op (read, or write when d_write = 1); latch d_wdata; set last_grant; move to BUSY_x.
  - d_read and d_write both high: write wins.
- BUSY_x: mem_addr, mem_read, mem_write and mem_wdata are driven only from the latched registers. Requester inputs have no combinational path to the mem outputs.
- Latency: request seen at edge N, so mem_read/mem_write is high in cycle N+1.
- Completion: when mem_resp = 1 in BUSY_x, in that same cycle:
  - x_resp = 1 and x_rdata = mem_rdata (combinational pass-through);
  - the other requester's resp = 0;
  - mem_read/mem_write stay asserted through this cycle;
  - the next state is IDLE and grant_x_cnt increments.
- i_rdata and d_rdata: driven with mem_rdata at all times. They are qualified only by the resp pulse.
- Minimum turnaround: resp at edge M, next grant decided in IDLE at edge M+1, and the new mem request is issued in cycle M+2. The IDLE cycle absorbs the requester deasserting its request after resp.
- mem_resp while in IDLE: ignored, with no resp pulse.
- Requester changes its inputs while in BUSY: no effect; the latched transaction is used.
- A requester dropping its request mid-BUSY: the transaction still completes and the resp is still pulsed.
- Counter overflow: all counters wrap modulo 2^32.
- conflict_cnt increments on each IDLE edge where both requests are pending.
- Reset mid-transaction: the arbiter returns to IDLE at the next edge and drops the transaction silently. It does not pulse a resp, and mem_read/mem_write go low in the following cycle.

Decomposition:
- Shared package cache_arbiter_pkg holds:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D};
  - requester_t enum {REQ_I, REQ_D};
  - localparam LINE_W = 256.
- One natural sub-module, arb_rr_pick: combinational. Inputs are pending_i, pending_d, last_grant and D_PRIORITY; outputs are grant_valid and grant_id.
- State, latches, response routing and counters stay in cache_arbiter.

Test Plan:
- Lone icache read at 0x0000_0060, mem_resp after 5 cycles with rdata = {8{32'hDEADBEEF}}:
  - mem_read = 1 from cycle 1 with mem_addr = 0x60;
  - i_resp pulses once with that line; d_resp stays 0;
  - grant_i_cnt = 1.
- Lone dcache write to 0x0000_1000 with d_wdata = {8{32'hA5A5A5A5}}:
  - mem_write = 1 and mem_wdata matches the written line;
  - mem_read = 0;
  - d_resp pulses once.
- Both request in the same cycle from reset, D_PRIORITY = 0:
  - D is served first, then I;
  - the next simultaneous pair serves D again, since last_grant = I at that point;
  - conflict_cnt increments on each contended IDLE edge.
- D_PRIORITY = 1, dcache re-requesting back-to-back with the icache pending:
  - D is granted every time;
  - I is granted only on an IDLE cycle where D is not pending.
- Icache changes i_addr to 0xFFFF_FFE0 mid-BUSY_I, and a spurious mem_resp is injected while in IDLE:
  - mem_addr stays at the original latched address;
  - no resp pulse results from the IDLE mem_resp.
- rst asserted two cycles into BUSY_D:
  - state returns to IDLE and mem_write = 0 the following cycle;
  - no d_resp pulse;
  - all counters read 0.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1 I/D cache arbiter: FSM states, requester ids and
// the default line width.
package cache_arbiter_pkg;

  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational grant selection between the icache and dcache requesters.
// grant_id / last_grant encoding: 0 = icache, 1 = dcache.
module arb_rr_pick #(
  parameter int D_PRIORITY = 0
) (
  input  logic pending_i,
  input  logic pending_d,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = pending_i | pending_d;
    grant_id    = 1'b0;
    // A tie goes to D under fixed priority, or when I was served last.
    if (pending_d && (!pending_i || (D_PRIORITY != 0) || !last_grant))
      grant_id = 1'b1;
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates the single line-wide memory port between the L1 icache and
// dcache; one transaction is latched and driven downstream until mem_resp.
module cache_arbiter #(
  parameter int LINE_W     = cache_arbiter_pkg::LINE_W,
  parameter int ADDR_W     = 32,
  parameter int D_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [31:0]       grant_i_cnt,
  output logic [31:0]       grant_d_cnt,
  output logic [31:0]       conflict_cnt
);
  import cache_arbiter_pkg::*;

  // Handshake: a requester holds its read/write level until its one-cycle
  // resp pulse; downstream, mem_read/mem_write stay high until mem_resp.
  arb_state_t state;
  requester_t last_grant;
  logic       pending_i;
  logic       pending_d;
  logic       grant_valid;
  logic       grant_id;

  assign pending_i = i_read;
  assign pending_d = d_read | d_write;

  arb_rr_pick #(
    .D_PRIORITY(D_PRIORITY)
  ) u_pick (
    .pending_i  (pending_i),
    .pending_d  (pending_d),
    .last_grant (last_grant == REQ_D),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_resp  = (state == BUSY_I) && mem_resp;
  assign d_resp  = (state == BUSY_D) && mem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= REQ_I;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      grant_i_cnt  <= '0;
      grant_d_cnt  <= '0;
      conflict_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending_i && pending_d)
            conflict_cnt <= conflict_cnt + 32'd1;
          if (grant_valid) begin
            mem_wdata <= d_wdata;
            if (grant_id) begin
              state      <= BUSY_D;
              last_grant <= REQ_D;
              mem_addr   <= d_addr;
              // A simultaneous read and write from the dcache is a writeback.
              mem_read   <= ~d_write;
              mem_write  <= d_write;
            end else begin
              state      <= BUSY_I;
              last_grant <= REQ_I;
              mem_addr   <= i_addr;
              mem_read   <= 1'b1;
              mem_write  <= 1'b0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (state == BUSY_I) grant_i_cnt <= grant_i_cnt + 32'd1;
            else                 grant_d_cnt <= grant_d_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a round-robin instance and a
// dcache-priority instance driven by per-scenario tasks.
module tb_cache_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Round-robin instance
  logic [31:0]  i_addr = '0, d_addr = '0, mem_addr;
  logic         i_read = 0, d_read = 0, d_write = 0, mem_resp = 0;
  logic [255:0] d_wdata = '0, mem_rdata = '0, i_rdata, d_rdata, mem_wdata;
  logic         i_resp, d_resp, mem_read, mem_write;
  logic [31:0]  grant_i_cnt, grant_d_cnt, conflict_cnt;

  // Fixed dcache-priority instance
  logic [31:0]  p_i_addr = '0, p_d_addr = '0, p_mem_addr;
  logic         p_i_read = 0, p_d_read = 0, p_d_write = 0, p_mem_resp = 0;
  logic [255:0] p_d_wdata = '0, p_mem_rdata = '0, p_i_rdata, p_d_rdata, p_mem_wdata;
  logic         p_i_resp, p_d_resp, p_mem_read, p_mem_write;
  logic [31:0]  p_grant_i_cnt, p_grant_d_cnt, p_conflict_cnt;

  logic [255:0] line_dead = {8{32'hDEADBEEF}};
  logic [255:0] line_a5   = {8{32'hA5A5A5A5}};
  logic [255:0] line_c3   = {8{32'hC3C3C3C3}};

  cache_arbiter #(.LINE_W(256), .ADDR_W(32), .D_PRIORITY(0)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .grant_i_cnt(grant_i_cnt), .grant_d_cnt(grant_d_cnt), .conflict_cnt(conflict_cnt)
  );

  cache_arbiter #(.LINE_W(256), .ADDR_W(32), .D_PRIORITY(1)) dut_p (
    .clk(clk), .rst(rst),
    .i_addr(p_i_addr), .i_read(p_i_read), .i_rdata(p_i_rdata), .i_resp(p_i_resp),
    .d_addr(p_d_addr), .d_read(p_d_read), .d_write(p_d_write), .d_wdata(p_d_wdata),
    .d_rdata(p_d_rdata), .d_resp(p_d_resp),
    .mem_addr(p_mem_addr), .mem_read(p_mem_read), .mem_write(p_mem_write),
    .mem_wdata(p_mem_wdata), .mem_rdata(p_mem_rdata), .mem_resp(p_mem_resp),
    .grant_i_cnt(p_grant_i_cnt), .grant_d_cnt(p_grant_d_cnt), .conflict_cnt(p_conflict_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000)
      $display("FAIL reset_ctl: got %b exp 0000", {mem_read, mem_write, i_resp, d_resp}); else passes++;
    checks++; if (mem_addr !== 32'h0) $display("FAIL reset_addr: got %h exp 0", mem_addr); else passes++;
    checks++; if (mem_wdata !== '0) $display("FAIL reset_wdata: got %h exp 0", mem_wdata); else passes++;
    checks++; if ({grant_i_cnt, grant_d_cnt, conflict_cnt} !== 96'h0)
      $display("FAIL reset_cnt: got %h %h %h exp 0", grant_i_cnt, grant_d_cnt, conflict_cnt); else passes++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lone_i_read();
    i_addr = 32'h0000_0060;
    i_read = 1'b1;
    tick();
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0)
      $display("FAIL li_issue: got rd=%b wr=%b exp rd=1 wr=0", mem_read, mem_write); else passes++;
    checks++; if (mem_addr !== 32'h60) $display("FAIL li_addr: got %h exp 00000060", mem_addr); else passes++;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (mem_read !== 1'b1 || i_resp !== 1'b0 || d_resp !== 1'b0)
        $display("FAIL li_wait%0d: got rd=%b ir=%b dr=%b exp 1 0 0", k, mem_read, i_resp, d_resp); else passes++;
    end
    mem_rdata = line_dead;
    mem_resp  = 1'b1;
    #1;
    checks++; if (i_resp !== 1'b1 || d_resp !== 1'b0 || mem_read !== 1'b1)
      $display("FAIL li_resp: got ir=%b dr=%b rd=%b exp 1 0 1", i_resp, d_resp, mem_read); else passes++;
    checks++; if (i_rdata !== line_dead) $display("FAIL li_rdata: got %h exp %h", i_rdata, line_dead); else passes++;
    tick();
    mem_resp = 1'b0;
    i_read   = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || i_resp !== 1'b0)
      $display("FAIL li_done: got rd=%b ir=%b exp 0 0", mem_read, i_resp); else passes++;
    checks++; if (grant_i_cnt !== 32'd1) $display("FAIL li_cnt: got %0d exp 1", grant_i_cnt); else passes++;
    tick();
  endtask

  task automatic test_lone_d_write();
    d_addr  = 32'h0000_1000;
    d_wdata = line_a5;
    d_write = 1'b1;
    d_read  = 1'b1;
    tick();
    checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0)
      $display("FAIL dw_issue: got wr=%b rd=%b exp wr=1 rd=0", mem_write, mem_read); else passes++;
    checks++; if (mem_addr !== 32'h1000) $display("FAIL dw_addr: got %h exp 00001000", mem_addr); else passes++;
    checks++; if (mem_wdata !== line_a5) $display("FAIL dw_wdata: got %h exp %h", mem_wdata, line_a5); else passes++;
    tick();
    mem_resp = 1'b1;
    #1;
    checks++; if (d_resp !== 1'b1 || i_resp !== 1'b0)
      $display("FAIL dw_resp: got dr=%b ir=%b exp 1 0", d_resp, i_resp); else passes++;
    tick();
    mem_resp = 1'b0;
    d_write  = 1'b0;
    d_read   = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0 || d_resp !== 1'b0)
      $display("FAIL dw_done: got wr=%b dr=%b exp 0 0", mem_write, d_resp); else passes++;
    checks++; if (grant_d_cnt !== 32'd1) $display("FAIL dw_cnt: got %0d exp 1", grant_d_cnt); else passes++;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    i_addr = 32'h0000_0200;
    d_addr = 32'h0000_0400;
    i_read = 1'b1;
    d_read = 1'b1;
    tick();
    checks++; if (mem_addr !== 32'h400 || mem_read !== 1'b1)
      $display("FAIL rr_first_d: got addr=%h rd=%b exp 00000400 1", mem_addr, mem_read); else passes++;
    checks++; if (conflict_cnt !== 32'd1) $display("FAIL rr_conf1: got %0d exp 1", conflict_cnt); else passes++;
    mem_rdata = line_c3;
    mem_resp  = 1'b1;
    #1;
    checks++; if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== line_c3)
      $display("FAIL rr_d_resp: got dr=%b ir=%b data=%h exp 1 0 %h", d_resp, i_resp, d_rdata, line_c3); else passes++;
    tick();
    mem_resp = 1'b0;
    d_read   = 1'b0;
    tick();
    checks++; if (mem_addr !== 32'h200 || mem_read !== 1'b1)
      $display("FAIL rr_then_i: got addr=%h rd=%b exp 00000200 1", mem_addr, mem_read); else passes++;
    mem_resp = 1'b1;
    #1;
    checks++; if (i_resp !== 1'b1 || d_resp !== 1'b0)
      $display("FAIL rr_i_resp: got ir=%b dr=%b exp 1 0", i_resp, d_resp); else passes++;
    tick();
    mem_resp = 1'b0;
    d_read   = 1'b1;
    tick();
    checks++; if (mem_addr !== 32'h400) $display("FAIL rr_second_d: got %h exp 00000400", mem_addr); else passes++;
    checks++; if (conflict_cnt !== 32'd2) $display("FAIL rr_conf2: got %0d exp 2", conflict_cnt); else passes++;
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    i_read   = 1'b0;
    d_read   = 1'b0;
    #1;
    checks++; if (grant_d_cnt !== 32'd2 || grant_i_cnt !== 32'd1)
      $display("FAIL rr_cnts: got d=%0d i=%0d exp d=2 i=1", grant_d_cnt, grant_i_cnt); else passes++;
    tick();
  endtask

  task automatic test_d_priority();
    do_reset();
    p_i_addr = 32'h0000_0800;
    p_d_addr = 32'h0000_0C00;
    p_i_read = 1'b1;
    p_d_read = 1'b1;
    tick();
    checks++; if (p_mem_addr !== 32'hC00) $display("FAIL pr_d1: got %h exp 00000c00", p_mem_addr); else passes++;
    p_mem_resp = 1'b1;
    tick();
    p_mem_resp = 1'b0;
    p_d_addr   = 32'h0000_0C20;
    tick();
    checks++; if (p_mem_addr !== 32'hC20) $display("FAIL pr_d2: got %h exp 00000c20", p_mem_addr); else passes++;
    p_mem_resp = 1'b1;
    #1;
    checks++; if (p_d_resp !== 1'b1 || p_i_resp !== 1'b0)
      $display("FAIL pr_d2_resp: got dr=%b ir=%b exp 1 0", p_d_resp, p_i_resp); else passes++;
    tick();
    p_mem_resp = 1'b0;
    p_d_read   = 1'b0;
    tick();
    checks++; if (p_mem_addr !== 32'h800 || p_mem_read !== 1'b1)
      $display("FAIL pr_i: got addr=%h rd=%b exp 00000800 1", p_mem_addr, p_mem_read); else passes++;
    p_mem_resp = 1'b1;
    tick();
    p_mem_resp = 1'b0;
    p_i_read   = 1'b0;
    #1;
    checks++; if (p_grant_d_cnt !== 32'd2 || p_grant_i_cnt !== 32'd1 || p_conflict_cnt !== 32'd2)
      $display("FAIL pr_cnts: got d=%0d i=%0d c=%0d exp 2 1 2", p_grant_d_cnt, p_grant_i_cnt, p_conflict_cnt); else passes++;
    tick();
  endtask

  task automatic test_busy_hold_and_idle_resp();
    do_reset();
    i_addr = 32'h0000_0100;
    i_read = 1'b1;
    tick();
    i_addr = 32'hFFFF_FFE0;
    tick();
    checks++; if (mem_addr !== 32'h100) $display("FAIL hold_addr: got %h exp 00000100", mem_addr); else passes++;
    i_read = 1'b0;
    tick();
    checks++; if (mem_read !== 1'b1) $display("FAIL hold_drop: got rd=%b exp 1", mem_read); else passes++;
    mem_resp = 1'b1;
    #1;
    checks++; if (i_resp !== 1'b1) $display("FAIL hold_resp: got %b exp 1", i_resp); else passes++;
    tick();
    #1;
    checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0)
      $display("FAIL idle_resp: got ir=%b dr=%b exp 0 0", i_resp, d_resp); else passes++;
    tick();
    mem_resp = 1'b0;
    #1;
    checks++; if (grant_i_cnt !== 32'd1 || mem_read !== 1'b0)
      $display("FAIL idle_cnt: got cnt=%0d rd=%b exp 1 0", grant_i_cnt, mem_read); else passes++;
  endtask

  task automatic test_reset_mid_busy();
    d_addr  = 32'h0000_2000;
    d_wdata = line_c3;
    d_write = 1'b1;
    tick();
    checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h2000)
      $display("FAIL rm_issue: got wr=%b addr=%h exp 1 00002000", mem_write, mem_addr); else passes++;
    tick();
    rst     = 1'b1;
    d_write = 1'b0;
    tick();
    checks++; if (mem_write !== 1'b0 || d_resp !== 1'b0)
      $display("FAIL rm_drop: got wr=%b dr=%b exp 0 0", mem_write, d_resp); else passes++;
    checks++; if ({grant_i_cnt, grant_d_cnt, conflict_cnt} !== 96'h0)
      $display("FAIL rm_cnt: got %h %h %h exp 0", grant_i_cnt, grant_d_cnt, conflict_cnt); else passes++;
    rst      = 1'b0;
    mem_resp = 1'b1;
    #1;
    checks++; if (d_resp !== 1'b0) $display("FAIL rm_no_resp: got %b exp 0", d_resp); else passes++;
    tick();
    mem_resp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lone_i_read();
    test_lone_d_write();
    test_round_robin();
    test_d_priority();
    test_busy_hold_and_idle_resp();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
